// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between a mul_div_unit and its requester
interface mul_div_unit_if #(parameter int DATA_WIDTH = 32);
   logic                  Start;
   logic [1:0]            MDOp;
   logic [DATA_WIDTH-1:0] SrcA;
   logic [DATA_WIDTH-1:0] SrcB;
   logic                  Busy;
   logic                  Done;
   logic [DATA_WIDTH-1:0] Hi;
   logic [DATA_WIDTH-1:0] Lo;
   logic                  DivByZero;
   modport master (output Start, MDOp, SrcA, SrcB, input Busy, Done, Hi, Lo, DivByZero);
   modport slave (input Start, MDOp, SrcA, SrcB, output Busy, Done, Hi, Lo, DivByZero);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle
module mul_div_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input logic           CLK,
   input logic           RST,
   mul_div_unit_if.slave bus
);
   localparam int W = DATA_WIDTH;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t               state, state_nxt;
   logic                 is_div, neg_q, neg_r, dbz;
   logic [W-1:0]         b_mag, hi_q, lo_q, a_in, b_in, quo, rem;
   logic [2*W-1:0]       acc, step, prod_neg;
   logic [CNT_WIDTH-1:0] cnt;
   logic [W:0]           mul_sum, rem_sh, rem_diff;
   logic                 accept, signed_in, div_zero, last;
   assign accept    = bus.Start && (state != CALC);
   assign signed_in = bus.MDOp[0];
   assign div_zero  = bus.MDOp[1] && (bus.SrcB == '0);
   assign a_in      = (signed_in && bus.SrcA[W-1]) ? -bus.SrcA : bus.SrcA;
   assign b_in      = (signed_in && bus.SrcB[W-1]) ? -bus.SrcB : bus.SrcB;
   assign last      = cnt == CNT_WIDTH'(W - 1);
   // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient bits}
   assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_mag} : '0);
   assign rem_sh    = {acc[2*W-1:W], acc[W-1]};
   assign rem_diff  = rem_sh - {1'b0, b_mag};
   assign step      = !is_div ? {mul_sum, acc[W-1:1]} :
                      rem_diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0} :
                      {rem_diff[W-1:0], acc[W-2:0], 1'b1};
   assign prod_neg  = -step;
   assign quo       = neg_q ? -step[W-1:0] : step[W-1:0];
   assign rem       = neg_r ? -step[2*W-1:W] : step[2*W-1:W];
   assign bus.Busy      = state == CALC;
   assign bus.Done      = state == DONE;
   assign bus.DivByZero = dbz;
   assign bus.Hi        = hi_q;
   assign bus.Lo        = lo_q;
   always_comb begin
      state_nxt = (state == CALC) ? (last ? DONE : CALC) :
                  !accept ? IDLE : div_zero ? DONE : CALC;
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dbz    <= 1'b0;
         b_mag  <= '0;
         acc    <= '0;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         dbz <= accept && div_zero;
         if (accept) begin
            is_div <= bus.MDOp[1];
            neg_q  <= signed_in && (bus.SrcA[W-1] ^ bus.SrcB[W-1]);
            neg_r  <= signed_in && bus.SrcA[W-1];
            b_mag  <= b_in;
            acc    <= {{W{1'b0}}, a_in};
            cnt    <= '0;
            if (div_zero) begin
               hi_q <= bus.SrcA;
               lo_q <= '1;
            end
         end else if (state == CALC) begin
            acc <= step;
            cnt <= cnt + CNT_WIDTH'(1);
            if (last) {hi_q, lo_q} <= is_div ? {rem, quo} : (neg_q ? prod_neg : step);
         end
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a scoreboard queue checked by an independent Done monitor
module tb_mul_div_unit;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          at;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   mul_div_unit_if #(.DATA_WIDTH(32)) bus();
   mul_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (.CLK(CLK), .RST(RST), .bus(bus));
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   always @(negedge CLK) begin
      if (RST && bus.Done === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: Done high with no pending operation (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("done_hi", bus.Hi, e.hi);
            check("done_lo", bus.Lo, e.lo);
            check("done_dbz", bus.DivByZero, e.dbz);
            check("done_cycle", cyc, e.at);
         end
      end else if (RST) check("dbz_without_done", bus.DivByZero, 0);
   end
   task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] hi, logic [31:0] lo, logic dbz, int lat);
      bus.Start = 1'b1;
      bus.MDOp  = op;
      bus.SrcA  = a;
      bus.SrcB  = b;
      sb.push_back('{hi, lo, dbz, cyc + lat});
      @(posedge CLK); #1;
      bus.Start = 1'b0;
      bus.MDOp  = ~op;
      bus.SrcA  = ~a;
      bus.SrcB  = ~b;
   endtask
   task automatic wait_done(output int busy_cnt);
      busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.Done === 1'b1) return;
         if (bus.Busy === 1'b1) busy_cnt++;
         @(posedge CLK); #1;
      end
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no Done within 100 cycles (cycle %0d)", cyc);
   endtask
   task automatic run(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                      logic [31:0] hi, logic [31:0] lo, logic dbz, int lat, int busy_exp);
      int bc;
      issue(op, a, b, hi, lo, dbz, lat);
      if (lat > 1) check({name, "_hold"}, {bus.Hi, bus.Lo}, {last_hi, last_lo});
      wait_done(bc);
      check({name, "_busy"}, bc, busy_exp);
      last_hi = hi;
      last_lo = lo;
      @(posedge CLK); #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int c;
      int bc;
      bus.Start = 1'b0;
      bus.MDOp  = 2'b00;
      bus.SrcA  = '0;
      bus.SrcB  = '0;
      #2 RST = 1'b0;
      #1;
      check("rst_busy", bus.Busy, 0);
      check("rst_done", bus.Done, 0);
      check("rst_dbz", bus.DivByZero, 0);
      check("rst_hilo", {bus.Hi, bus.Lo}, 64'h0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      run("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 32);
      run("mult_neg", 2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 32);
      run("mult_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 32);
      run("div_neg", 2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 32);
      run("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 32);
      run("div_negb", 2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 32);
      run("divu_zero", 2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1, 0);
      run("div_zero", 2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1, 0);
      run("divu_small", 2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33, 32);
      run("divu_big", 2'b10, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0, 33, 32);
      // Start pulse mid-operation is ignored; Start held in the Done cycle chains a second op
      c = cyc;
      issue(2'b00, 32'h7, 32'h6, 32'h0, 32'h0000002A, 1'b0, 33);
      while (cyc < c + 10) begin @(posedge CLK); #1; end
      bus.Start = 1'b1; bus.MDOp = 2'b00; bus.SrcA = 32'h3; bus.SrcB = 32'h3;
      @(posedge CLK); #1;
      bus.Start = 1'b0;
      while (cyc < c + 33) begin @(posedge CLK); #1; end
      check("b2b_done_at_33", bus.Done, 1);
      issue(2'b00, 32'h9, 32'h9, 32'h0, 32'h00000051, 1'b0, 33);
      wait_done(bc);
      check("b2b_second_at_66", cyc, c + 66);
      @(posedge CLK); #1;
      // Reset mid-divide: immediate clear, no Done pulse, normal operation afterwards
      c = cyc;
      bus.Start = 1'b1; bus.MDOp = 2'b10; bus.SrcA = 32'h1000; bus.SrcB = 32'h3;
      @(posedge CLK); #1;
      bus.Start = 1'b0;
      while (cyc < c + 15) begin @(posedge CLK); #1; end
      RST = 1'b0;
      #1;
      check("abort_busy", bus.Busy, 0);
      check("abort_hilo", {bus.Hi, bus.Lo}, 64'h0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      last_hi = '0;
      last_lo = '0;
      run("after_rst", 2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33, 32);
      repeat (40) @(posedge CLK);
      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand, Hi and Lo width.
REQ-002 Parameter CNT_WIDTH, default 6: iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
REQ-003 Port CLK, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port RST, input, 1: asynchronous, active-low reset.
REQ-005 Port Start, input, 1: operation request, sampled on the rising edge.
REQ-006 Port MDOp, input, 2: operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 Ports SrcA and SrcB, input, DATA_WIDTH each: operands; SrcA is the multiplicand or dividend, SrcB is the multiplier or divisor.
REQ-008 Port Busy, output, 1: high while iterating.
REQ-009 Port Done, output, 1: one-cycle pulse; Hi and Lo hold the new result during this cycle.
REQ-010 Ports Hi and Lo, output, DATA_WIDTH each: result registers.
REQ-011 Port DivByZero, output, 1: qualifies Done; high when the completed operation was a divide with SrcB=0.

Function
REQ-012 States: IDLE, CALC, DONE. Busy=1 only in CALC. Done=1 only in DONE.
REQ-013 Start is accepted only in IDLE or DONE. On acceptance, the block latches MDOp, SrcA and SrcB, clears the counter and enters CALC. Start in CALC is ignored and leaves the latched operands unchanged.
REQ-014 Operand preparation:
- Signed ops (MULT, DIV) take the magnitudes of SrcA and SrcB and record the result signs.
- Unsigned ops use the operands unmodified.
REQ-015 Multiply: radix-2 shift-add, one bit per cycle, DATA_WIDTH CALC cycles, giving a 2*DATA_WIDTH-bit product.
REQ-016 Divide: restoring shift-subtract, one quotient bit per cycle, DATA_WIDTH CALC cycles.
REQ-017 On the edge that ends the last CALC cycle, the block performs sign correction, writes Hi and Lo, and enters DONE:
- Multiply: {Hi,Lo} = product, two's-complement negated if the operand signs differ (MULT only).
- Divide: Lo = quotient, negated if the operand signs differ; Hi = remainder, carrying the sign of SrcA (DIV only).
REQ-018 Latency: Start high in cycle 0 and accepted -> Busy high in cycles 1..DATA_WIDTH -> Done high in cycle DATA_WIDTH+1 (cycle 33 at default width).
REQ-019 DONE lasts exactly one cycle. The next state is CALC if Start=1 in that cycle (back-to-back operation), otherwise IDLE.
REQ-020 Divide by zero (DIVU or DIV with latched SrcB=0):
- CALC is skipped; the block enters DONE on the edge after acceptance.
- Hi = SrcA unmodified; Lo = all ones; DivByZero = 1 during that Done.
REQ-021 DIV overflow (0x80000000 / 0xFFFFFFFF): Lo = 0x80000000, Hi = 0, with no flag raised.
REQ-022 DivByZero = 0 whenever Done = 0.
REQ-023 Hi and Lo hold their values at all times except the write in REQ-017/REQ-020; a new Start does not clear them.
REQ-024 Input changes on SrcA, SrcB or MDOp after acceptance shall not affect the in-flight result.

Reset
REQ-025 With RST low, immediately and independent of CLK: state = IDLE; counter = 0; Busy = 0; Done = 0; DivByZero = 0; Hi = 0; Lo = 0; all internal operand and accumulator registers = 0.
REQ-026 Reset asserted mid-operation aborts the operation: no Done pulse, and Hi/Lo are not updated with partial results.
REQ-027 In the first cycle after RST deasserts, the block is in IDLE and accepts Start.

Verification
REQ-028 MULTU 0xFFFFFFFF * 0xFFFFFFFF, Start in cycle 0 -> Busy high in cycles 1..32; Done in cycle 33 with Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-029 MULT 0xFFFFFFFD (-3) * 0x00000005 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
REQ-030 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-031 DIVU 0x00000064 / 0 -> Done in cycle 1 with DivByZero=1, Hi=0x00000064, Lo=0xFFFFFFFF; Busy never asserts.
REQ-032 Start pulsed with new operands in cycle 10 of an active MULTU 7*6 -> pulse ignored; Done in cycle 33 with Hi=0, Lo=0x0000002A; Start held in cycle 33 -> second operation completes in cycle 66.
REQ-033 RST low in cycle 15 of a DIVU -> Busy=0, Hi=Lo=0 asynchronously; no Done pulse; Start after release completes normally.
